// File: rtl/vip_slink_pkg.sv
// Shared constants for the serial-link loopback VIP: LFSR taps, default seed and counter width.
package vip_slink_pkg;

  localparam int unsigned CntW  = 16;
  localparam int unsigned LfsrW = 16;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps land on state bits 0,2,3,5.
  localparam logic [LfsrW-1:0] LfsrTaps        = 16'h002D;
  localparam logic [LfsrW-1:0] LfsrSeedDefault = 16'hACE1;
  localparam logic [CntW-1:0]  CntMax          = 16'hFFFF;

  function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] state);
    return {^(state & LfsrTaps), state[LfsrW-1:1]};
  endfunction

endpackage

// File: rtl/vip_slink_delay_line.sv
// One channel of the loopback: circular delay buffer of {rcv_clk, lanes}, error-injection mux,
// registered output and saturating injected-error counter. Pointers and LFSR come from the top.
module vip_slink_delay_line
  import vip_slink_pkg::*;
#(
  parameter int unsigned NumLanes = 4,
  parameter int unsigned MaxDelay = 16,
  parameter int unsigned DlyW     = $clog2(MaxDelay),
  parameter int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [DlyW-1:0]     wptr_i,
  input  logic [DlyW-1:0]     rptr_i,
  input  logic                inj_i,
  input  logic [LaneW-1:0]    lane_idx_i,
  input  logic                rcv_clk_i,
  input  logic [NumLanes-1:0] lanes_i,
  output logic                rcv_clk_o,
  output logic [NumLanes-1:0] lanes_o,
  output logic [CntW-1:0]     err_cnt_o
);

  localparam int unsigned EntW = NumLanes + 1;

  logic [EntW-1:0]     mem_q [MaxDelay];
  logic [EntW-1:0]     wr_ent;
  logic [EntW-1:0]     out_d, out_q;
  logic [NumLanes-1:0] inj_mask;
  logic [CntW-1:0]     cnt_d, cnt_q;

  always_comb begin
    inj_mask = '0;
    if (inj_i) inj_mask[lane_idx_i] = 1'b1;
  end

  // Injection only ever touches lane bits; rcv_clk passes through untouched.
  assign wr_ent = {rcv_clk_i, lanes_i ^ inj_mask};

  // Write-first: a zero-delay read returns this cycle's capture, not the stale slot.
  always_comb begin
    out_d = '0;
    cnt_d = cnt_q;
    if (en_i) begin
      out_d = (rptr_i == wptr_i) ? wr_ent : mem_q[rptr_i];
      if (inj_i && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxDelay; i++) mem_q[i] <= '0;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      if (en_i) mem_q[wptr_i] <= wr_ent;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign rcv_clk_o = out_q[EntW-1];
  assign lanes_o   = out_q[NumLanes-1:0];
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/vip_slink_loopback.sv
// Serial-link loopback VIP: delays each channel's forwarded clock and lanes by cfg_delay_i+1 cycles,
// optionally flipping one LFSR-selected lane per capture. Holds the shared write pointer and LFSR.
module vip_slink_loopback
  import vip_slink_pkg::*;
#(
  parameter int unsigned      NumChan  = 1,
  parameter int unsigned      NumLanes = 4,
  parameter int unsigned      MaxDelay = 16,
  parameter logic [LfsrW-1:0] LfsrSeed = LfsrSeedDefault,
  localparam int unsigned     DlyW     = $clog2(MaxDelay)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cfg_en_i,
  input  logic [DlyW-1:0]                    cfg_delay_i,
  input  logic [NumChan-1:0]                 err_inj_i,
  input  logic [NumChan-1:0]                 slink_rcv_clk_i,
  input  logic [NumChan-1:0][NumLanes-1:0]   slink_i,
  output logic [NumChan-1:0]                 slink_rcv_clk_o,
  output logic [NumChan-1:0][NumLanes-1:0]   slink_o,
  output logic [NumChan-1:0][CntW-1:0]       err_cnt_o
);

  localparam int unsigned LaneW = (NumLanes > 1) ? $clog2(NumLanes) : 1;

  logic [DlyW-1:0]  wptr_d, wptr_q;
  logic [DlyW-1:0]  rptr;
  logic [LfsrW-1:0] lfsr_d, lfsr_q;
  logic [LaneW-1:0] lane_idx;

  // MaxDelay is a power of two, so plain wrap-around subtraction is the modulo.
  assign rptr = wptr_q - cfg_delay_i;

  always_comb begin
    wptr_d = wptr_q;
    lfsr_d = lfsr_q;
    if (cfg_en_i) begin
      wptr_d = wptr_q + 1'b1;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      lfsr_q <= LfsrSeed;
    end else begin
      wptr_q <= wptr_d;
      lfsr_q <= lfsr_d;
    end
  end

  if (NumLanes > 1) begin : g_lane_idx
    assign lane_idx = lfsr_q[LaneW-1:0];
  end else begin : g_lane_idx_single
    assign lane_idx = '0;
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    vip_slink_delay_line #(
      .NumLanes (NumLanes),
      .MaxDelay (MaxDelay),
      .DlyW     (DlyW),
      .LaneW    (LaneW)
    ) u_dly (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (cfg_en_i),
      .wptr_i     (wptr_q),
      .rptr_i     (rptr),
      .inj_i      (err_inj_i[c]),
      .lane_idx_i (lane_idx),
      .rcv_clk_i  (slink_rcv_clk_i[c]),
      .lanes_i    (slink_i[c]),
      .rcv_clk_o  (slink_rcv_clk_o[c]),
      .lanes_o    (slink_o[c]),
      .err_cnt_o  (err_cnt_o[c])
    );
  end

  always_ff @(posedge clk_i) begin
    assert ((NumLanes >= 1) && ((NumLanes & (NumLanes - 1)) == 0))
      else $error("NumLanes must be a power of two");
    assert ((MaxDelay >= 2) && ((MaxDelay & (MaxDelay - 1)) == 0))
      else $error("MaxDelay must be a power of two and at least 2");
    assert (LfsrSeed != '0)
      else $error("LfsrSeed must be nonzero");
  end

endmodule

// File: tb/tb_vip_slink_loopback.sv
// Randomised bench for vip_slink_loopback against a history-based reference model.
module tb_vip_slink_loopback;

  localparam int NC = 2;
  localparam int NL = 4;
  localparam int MD = 16;
  localparam int DW = 4;
  localparam int HN = 4096;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_en = 1'b0;
  logic [DW-1:0]          cfg_delay = '0;
  logic [NC-1:0]          err_inj = '0;
  logic [NC-1:0]          rcv_clk_in = '0;
  logic [NC-1:0][NL-1:0]  din = '0;
  logic [NC-1:0]          rcv_clk_out;
  logic [NC-1:0][NL-1:0]  dout;
  logic [NC-1:0][15:0]    cnt;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  vip_slink_loopback #(
    .NumChan  (NC),
    .NumLanes (NL),
    .MaxDelay (MD),
    .LfsrSeed (16'hACE1)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cfg_en_i        (cfg_en),
    .cfg_delay_i     (cfg_delay),
    .err_inj_i       (err_inj),
    .slink_rcv_clk_i (rcv_clk_in),
    .slink_i         (din),
    .slink_rcv_clk_o (rcv_clk_out),
    .slink_o         (dout),
    .err_cnt_o       (cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Reference model: every enabled capture is appended to a history; the output loaded on an
  // enabled edge is the capture cfg_delay entries back (zero if none since reset).
  logic [NL:0]   hist  [NC][HN];
  logic [NL-1:0] clean [NC][HN];
  bit            injd  [NC][HN];
  int            n_m;
  logic [15:0]   lfsr_m;
  logic [NL:0]   exp_ent   [NC];
  logic [NL-1:0] exp_clean [NC];
  bit            exp_inj   [NC];
  logic [15:0]   exp_cnt   [NC];
  logic [NL-1:0] mask_m;
  int            idx_m, src_m;

  task automatic model_reset();
    n_m = 0;
    lfsr_m = 16'hACE1;
    for (int c = 0; c < NC; c++) begin
      exp_ent[c] = '0;
      exp_clean[c] = '0;
      exp_inj[c] = 1'b0;
      exp_cnt[c] = '0;
    end
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      if (cfg_en) begin
        idx_m = n_m % HN;
        for (int c = 0; c < NC; c++) begin
          mask_m = err_inj[c] ? (NL'(1) << lfsr_m[1:0]) : '0;
          hist[c][idx_m]  = {rcv_clk_in[c], din[c] ^ mask_m};
          clean[c][idx_m] = din[c];
          injd[c][idx_m]  = err_inj[c];
          if (err_inj[c] && exp_cnt[c] != 16'hFFFF) exp_cnt[c] = exp_cnt[c] + 16'd1;
          if (n_m >= int'(cfg_delay)) begin
            src_m = (n_m - int'(cfg_delay)) % HN;
            exp_ent[c]   = hist[c][src_m];
            exp_clean[c] = clean[c][src_m];
            exp_inj[c]   = injd[c][src_m];
          end else begin
            exp_ent[c] = '0;
            exp_clean[c] = '0;
            exp_inj[c] = 1'b0;
          end
        end
        n_m++;
        lfsr_m = lfsr_step(lfsr_m);
      end else begin
        for (int c = 0; c < NC; c++) begin
          exp_ent[c] = '0;
          exp_clean[c] = '0;
          exp_inj[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("lanes_ch%0d", c), 32'(dout[c]), 32'(exp_ent[c][NL-1:0]));
        chk($sformatf("rcv_clk_ch%0d", c), 32'(rcv_clk_out[c]), 32'(exp_ent[c][NL]));
        chk($sformatf("err_cnt_ch%0d", c), 32'(cnt[c]), 32'(exp_cnt[c]));
        if (exp_inj[c])
          chk($sformatf("one_lane_flipped_ch%0d", c), $countones(dout[c] ^ exp_clean[c]), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    for (int c = 0; c < NC; c++) din[c] = NL'($urandom);
    rcv_clk_in = NC'($urandom);
  endtask

  logic [NL-1:0] prev0, prev1;
  int hits, hit_at, first_nz;
  logic [NL-1:0] q[$];

  initial begin
    run = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();

    chk("lfsr_model_step1", lfsr_step(16'hACE1), 32'h5670);
    chk("lfsr_model_step2", lfsr_step(16'h5670), 32'hAB38);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_rcv_clk", 32'(rcv_clk_out), 32'h0);
    chk("reset_cnt", 32'(cnt), 32'h0);

    // Zero delay: output is last cycle's input.
    rst_n = 1'b1;
    cfg_en = 1'b1;
    cfg_delay = 4'd0;
    for (int i = 0; i < 30; i++) begin
      din[0] = NL'(i);
      din[1] = ~NL'(i);
      rcv_clk_in = i[0] ? 2'b11 : 2'b00;
      prev0 = din[0];
      prev1 = din[1];
      tick();
      chk("d0_ch0_prev_input", 32'(dout[0]), 32'(prev0));
      chk("d0_ch1_prev_input", 32'(dout[1]), 32'(prev1));
    end

    // Maximum delay: a single pulse reappears exactly 16 cycles later, after pointer wrap.
    cfg_delay = 4'd15;
    din = '0;
    rcv_clk_in = '0;
    repeat (20) tick();
    din[0] = 4'hA;
    hits = 0;
    hit_at = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) din[0] = 4'h0;
      if (dout[0] == 4'hA) begin
        hits++;
        hit_at = k;
      end
    end
    chk("pulse_hits", hits, 32'd1);
    chk("pulse_latency", hit_at, 32'd16);

    // Error injection on channel 0 only for 20 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg_delay = 4'd2;
    err_inj = 2'b01;
    for (int i = 0; i < 20; i++) begin
      drive_random();
      tick();
    end
    err_inj = '0;
    repeat (5) begin
      drive_random();
      tick();
    end
    chk("inj_cnt_ch0", 32'(cnt[0]), 32'd20);
    chk("inj_cnt_ch1", 32'(cnt[1]), 32'd0);

    // Enable gap of 5 cycles mid-stream.
    cfg_delay = 4'd5;
    repeat (10) begin
      drive_random();
      tick();
    end
    cfg_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_random();
      tick();
      chk("gap_dout_zero", 32'(dout), 32'h0);
      chk("gap_rcv_clk_zero", 32'(rcv_clk_out), 32'h0);
    end
    cfg_en = 1'b1;
    repeat (15) begin
      drive_random();
      tick();
    end

    // Delay switch 3 -> 7: repeats earlier entries from the next cycle on.
    cfg_delay = 4'd3;
    q.delete();
    for (int i = 0; i < 15; i++) begin
      din[0] = NL'(i);
      q.push_back(din[0]);
      tick();
      if (i >= 3) chk("d3_output", 32'(dout[0]), 32'(q[q.size() - 4]));
    end
    cfg_delay = 4'd7;
    for (int i = 15; i < 25; i++) begin
      din[0] = NL'(i);
      q.push_back(din[0]);
      tick();
      chk("d7_output", 32'(dout[0]), 32'(q[q.size() - 8]));
    end

    // Asynchronous reset mid-stream at delay 4.
    cfg_delay = 4'd4;
    repeat (10) begin
      drive_random();
      din[0] = 4'hF;
      tick();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout), 32'h0);
    chk("async_rst_rcv_clk", 32'(rcv_clk_out), 32'h0);
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    din[0] = 4'h9;
    din[1] = 4'h5;
    first_nz = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_nz < 0 && dout[0] != 4'h0) first_nz = k;
    end
    chk("post_rst_first_data", first_nz, 32'd5);

    // Free-running random traffic with random config changes.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      err_inj = NC'($urandom_range(0, 3) == 0 ? $urandom : 0);
      cfg_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) cfg_delay = DW'($urandom);
      tick();
    end

    cfg_en = 1'b0;
    repeat (3) tick();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
